instruction_fetch_unit: RTL and testbench

Parametrised instruction fetch front end for the CPU. It replaces the lock-step "fetch one, wait for valid, advance PC" loop with a free-running PC, up to FIFO_DEPTH in-flight memory requests and a prefetch FIFO. It delivers instructions to decode over a valid/ready handshake and supports redirects (branch/jump), which flush the FIFO and discard stale responses. It sits between the instruction memory AXI bridge and the control/decode logic.

---
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: free-running prefetch front end with credit-limited requests, prefetch FIFO and redirect flush.
//   i_Clock, i_Reset (sync, active low)
//   o_Req_Valid/o_Req_Addr/i_Req_Ready      : fetch request to instruction memory
//   i_Rsp_Valid/i_Rsp_Data/i_Rsp_Error      : in-order responses, no backpressure
//   o_Instr_Valid/o_Instruction/o_Instr_PC/o_Instr_Fault/i_Instr_Ready : head of FIFO to decode
//   i_Redirect_Valid/i_Redirect_PC          : flush and restart fetch
module instruction_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    output logic            o_Req_Valid,
    output logic [XLEN-1:0] o_Req_Addr,
    input  logic            i_Req_Ready,
    input  logic            i_Rsp_Valid,
    input  logic [XLEN-1:0] i_Rsp_Data,
    input  logic            i_Rsp_Error,
    output logic            o_Instr_Valid,
    output logic [XLEN-1:0] o_Instruction,
    output logic [XLEN-1:0] o_Instr_PC,
    output logic            o_Instr_Fault,
    input  logic            i_Instr_Ready,
    input  logic            i_Redirect_Valid,
    input  logic [XLEN-1:0] i_Redirect_PC
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]            rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]              outstanding_q, outstanding_d;
    logic [CW-1:0]              discard_q, discard_d;
    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                       misalign_q, misalign_d;
    logic [XLEN-1:0]            instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]            pc_q    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      fault_q;

    logic            req_fire, pop, rsp_drop, push_rsp, push_fault, push, push_flt;
    logic [XLEN-1:0] push_instr, push_pc;
    logic [CW:0]     credit_used;

    // Every slot is either already in the FIFO or reserved by an in-flight request, so pushes never overflow.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    assign o_Req_Valid   = i_Reset && state_q == FETCH && credit_used < DEPTH_C && !i_Redirect_Valid;
    assign o_Req_Addr    = fetch_pc_q;
    assign o_Instr_Valid = i_Reset && count_q != '0 && !i_Redirect_Valid;
    assign o_Instruction = instr_q[rd_ptr_q];
    assign o_Instr_PC    = pc_q[rd_ptr_q];
    assign o_Instr_Fault = fault_q[rd_ptr_q];

    always_comb begin
        req_fire      = o_Req_Valid && i_Req_Ready;
        pop           = o_Instr_Valid && i_Instr_Ready;
        rsp_drop      = i_Rsp_Valid && discard_q != '0;
        // Once halted, responses from requests issued before the error are dropped.
        push_rsp      = i_Rsp_Valid && discard_q == '0 && state_q == FETCH && !i_Redirect_Valid;
        push_fault    = misalign_q && !i_Redirect_Valid;
        push          = push_rsp || push_fault;
        push_flt      = push_fault || i_Rsp_Error;
        push_instr    = push_flt ? '0 : i_Rsp_Data;
        push_pc       = push_fault ? fetch_pc_q : rsp_pc_q;
        fetch_pc_d    = i_Redirect_Valid ? i_Redirect_PC : fetch_pc_q + XLEN'({req_fire, 2'b00});
        // rsp_pc tracks the address of the next non-discarded response.
        rsp_pc_d      = i_Redirect_Valid ? i_Redirect_PC : rsp_pc_q + XLEN'({push_rsp, 2'b00});
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_Rsp_Valid);
        discard_d     = i_Redirect_Valid ? outstanding_q - CW'(i_Rsp_Valid) : discard_q - CW'(rsp_drop);
        count_d       = i_Redirect_Valid ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = i_Redirect_Valid ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d      = i_Redirect_Valid ? '0 : wr_ptr_q + PW'(push);
        misalign_d    = i_Redirect_Valid && i_Redirect_PC[1:0] != 2'b00;
        // A misaligned target halts straight away so no request is ever issued for it.
        state_d       = i_Redirect_Valid ? (misalign_d ? HALT : FETCH) :
                        (push_rsp && i_Rsp_Error) ? HALT : state_q;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            misalign_q    <= 1'b0;
            fault_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            misalign_q    <= misalign_d;
            if (push) begin
                instr_q[wr_ptr_q] <= push_instr;
                pc_q[wr_ptr_q]    <= push_pc;
                fault_q[wr_ptr_q] <= push_flt;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with an in-order memory model for instruction_fetch_unit.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic        o_Req_Valid;
    logic [31:0] o_Req_Addr;
    logic        i_Req_Ready = 1'b0;
    logic        i_Rsp_Valid = 1'b0;
    logic [31:0] i_Rsp_Data = '0;
    logic        i_Rsp_Error = 1'b0;
    logic        o_Instr_Valid;
    logic [31:0] o_Instruction;
    logic [31:0] o_Instr_PC;
    logic        o_Instr_Fault;
    logic        i_Instr_Ready = 1'b0;
    logic        i_Redirect_Valid = 1'b0;
    logic [31:0] i_Redirect_PC = '0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .i_Clock(clk), .i_Reset(i_Reset),
        .o_Req_Valid(o_Req_Valid), .o_Req_Addr(o_Req_Addr), .i_Req_Ready(i_Req_Ready),
        .i_Rsp_Valid(i_Rsp_Valid), .i_Rsp_Data(i_Rsp_Data), .i_Rsp_Error(i_Rsp_Error),
        .o_Instr_Valid(o_Instr_Valid), .o_Instruction(o_Instruction), .o_Instr_PC(o_Instr_PC),
        .o_Instr_Fault(o_Instr_Fault), .i_Instr_Ready(i_Instr_Ready),
        .i_Redirect_Valid(i_Redirect_Valid), .i_Redirect_PC(i_Redirect_PC)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic flt; int cy; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    mem_t        mem_q[$];
    int          cyc = 0, lat = 1, t0 = 0, base = 0, req_cnt = 0, n_checks = 0, n_errors = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins, input logic flt, input int cy);
        exp_t e;
        e.pc = pc; e.ins = ins; e.flt = flt; e.cy = cy;
        exp_q.push_back(e);
    endtask

    // Monitor: records accepted requests into the memory model and scores delivered instructions.
    always @(negedge clk) begin
        exp_t e;
        mem_t m;
        if (!i_Reset) mem_q.delete();
        else begin
            if (o_Req_Valid && i_Req_Ready) begin
                req_cnt++;
                m.addr = o_Req_Addr; m.due = cyc + lat;
                mem_q.push_back(m);
                if (req_q.size() != 0) chk("req_addr", o_Req_Addr, req_q.pop_front());
            end
            if (o_Instr_Valid && i_Instr_Ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_instr: got pc %h, nothing expected (cycle %0d)", o_Instr_PC, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", o_Instr_PC, e.pc);
                    chk("instruction", o_Instruction, e.ins);
                    chk("instr_fault", 32'(o_Instr_Fault), 32'(e.flt));
                    if (e.cy >= 0) chk("instr_cycle", 32'(cyc), 32'(e.cy));
                end
            end
        end
    end

    // Memory: returns the request address as data, in order, after lat cycles.
    always @(posedge clk) begin
        mem_t m;
        #1;
        if (i_Reset && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            i_Rsp_Valid = 1'b1;
            i_Rsp_Error = err_en && m.addr == err_addr;
            i_Rsp_Data  = i_Rsp_Error ? 32'hDEAD_BEEF : m.addr;
        end else begin
            i_Rsp_Valid = 1'b0;
            i_Rsp_Error = 1'b0;
            i_Rsp_Data  = '0;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        i_Reset = 1'b0; i_Redirect_Valid = 1'b0; i_Instr_Ready = 1'b0; err_en = 1'b0;
        exp_q.delete(); req_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(o_Req_Valid), 32'd0);
        chk("rst_req_addr", o_Req_Addr, 32'h0);
        chk("rst_instr_valid", 32'(o_Instr_Valid), 32'd0);
        chk("rst_instruction", o_Instruction, 32'h0);
        chk("rst_instr_pc", o_Instr_PC, 32'h0);
        chk("rst_instr_fault", 32'(o_Instr_Fault), 32'd0);
    endtask

    task automatic release_rst(input int l, input logic rdy);
        lat = l; i_Req_Ready = 1'b1; i_Instr_Ready = rdy;
        base = req_cnt;
        @(posedge clk); #1;
        i_Reset = 1'b1; t0 = cyc;
    endtask

    task automatic drain(input logic stop);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        chk("req_left", 32'(req_q.size()), 32'd0);
        if (stop) i_Instr_Ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_Redirect_Valid = 1'b1; i_Redirect_PC = pc;
        #1;
        chk("redir_req_valid", 32'(o_Req_Valid), 32'd0);
        chk("redir_instr_valid", 32'(o_Instr_Valid), 32'd0);
        @(posedge clk); #1;
        i_Redirect_Valid = 1'b0;
    endtask

    initial begin
        // Back-to-back streaming from reset.
        do_reset();
        release_rst(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(32'(4 * i));
            push_exp(32'(4 * i), 32'(4 * i), 1'b0, t0 + 2 + i);
        end
        drain(1'b1);

        // Decode stalled: credit limit stops requests at FIFO_DEPTH.
        do_reset();
        release_rst(1, 1'b0);
        for (int i = 0; i < 5; i++) req_q.push_back(32'(4 * i));
        repeat (10) @(posedge clk);
        #1;
        chk("stall_req_count", 32'(req_cnt - base), 32'd4);
        chk("stall_req_valid", 32'(o_Req_Valid), 32'd0);
        chk("stall_instr_valid", 32'(o_Instr_Valid), 32'd1);
        chk("stall_head_pc", o_Instr_PC, 32'h0);
        for (int i = 0; i < 5; i++) push_exp(32'(4 * i), 32'(4 * i), 1'b0, -1);
        i_Instr_Ready = 1'b1;
        drain(1'b1);

        // Redirect with two stale responses in flight.
        do_reset();
        release_rst(3, 1'b1);
        req_q.push_back(32'h0); req_q.push_back(32'h4);
        req_q.push_back(32'h100); req_q.push_back(32'h104);
        push_exp(32'h100, 32'h100, 1'b0, t0 + 7);
        push_exp(32'h104, 32'h104, 1'b0, t0 + 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect(32'h100);
        drain(1'b1);

        // Bus error on 0x8 halts fetch until a redirect.
        do_reset();
        err_en = 1'b1; err_addr = 32'h8;
        release_rst(1, 1'b1);
        for (int i = 0; i < 4; i++) req_q.push_back(32'(4 * i));
        push_exp(32'h0, 32'h0, 1'b0, t0 + 2);
        push_exp(32'h4, 32'h4, 1'b0, t0 + 3);
        push_exp(32'h8, 32'h0, 1'b1, t0 + 4);
        drain(1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("halt_req_count", 32'(req_cnt - base), 32'd4);
        chk("halt_req_valid", 32'(o_Req_Valid), 32'd0);
        err_en = 1'b0;
        req_q.push_back(32'h40); req_q.push_back(32'h44);
        push_exp(32'h40, 32'h40, 1'b0, -1);
        push_exp(32'h44, 32'h44, 1'b0, -1);
        redirect(32'h40);
        drain(1'b1);

        // Misaligned redirect gives one fault entry and no request.
        do_reset();
        release_rst(1, 1'b1);
        push_exp(32'h102, 32'h0, 1'b1, t0 + 2);
        redirect(32'h102);
        drain(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("misalign_req_count", 32'(req_cnt - base), 32'd0);
        req_q.push_back(32'h200); req_q.push_back(32'h204);
        push_exp(32'h200, 32'h200, 1'b0, -1);
        push_exp(32'h204, 32'h204, 1'b0, -1);
        redirect(32'h200);
        drain(1'b1);

        // Fetch address wraps at the top of the address space.
        do_reset();
        release_rst(1, 1'b1);
        req_q.push_back(32'hFFFF_FFF8); req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0);
        push_exp(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0, t0 + 3);
        push_exp(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, t0 + 4);
        push_exp(32'h0, 32'h0, 1'b0, t0 + 5);
        redirect(32'hFFFF_FFF8);
        drain(1'b1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
